logic_pipe_nb: RTL and testbench

- Parametrised successor to the fixed 16-bit per-bit AND array.
- Applies a selectable bitwise operation (AND/OR/XOR/NOR) across WIDTH-bit operands.
- Carries each result through a STAGES-deep registered pipeline. This models the phase-per-gate latency of the adiabatic datapath.
- Adds a valid/ready handshake with full backpressure and a saturating completed-operation counter. Sits between the operand source and the ALU result mux.

---
 rtl/logic_pipe_nb.sv | 91 +++++++++
 tb/tb_logic_pipe_nb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_pipe_nb.sv
// logic_pipe_nb: bitwise AND/OR/XOR/NOR across WIDTH-bit operands carried through a
// STAGES-deep valid/ready pipeline with full backpressure and a saturating completion counter.
// Optional feature macro LOGIC_PIPE_ZERO_FLAG_EN adds an out_zero flag travelling with each result.
module logic_pipe_nb #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clkpos,
  input  logic             rstneg,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] done_cnt
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

`ifdef LOGIC_PIPE_ZERO_FLAG_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  logic [STAGES-1:0] r_vld;
  logic [DW-1:0]     r_dat [STAGES];
  logic [CNT_W-1:0]  r_cnt;
  logic [STAGES-1:0] w_ready;
  logic              w_acc;
  logic [WIDTH-1:0]  w_res;
  logic [DW-1:0]     w_in;

  // Selected bitwise operation on the offered operands
  always_comb begin
    w_res = op == 2'b00 ? a & b :
            op == 2'b01 ? a | b :
            op == 2'b10 ? a ^ b : ~(a | b);
  end

`ifdef LOGIC_PIPE_ZERO_FLAG_EN
  assign w_in     = {~|w_res, w_res};
  assign out_zero = r_dat[STAGES-1][WIDTH];
`else
  assign w_in = w_res;
`endif

  // Stage i may load when it or any stage after it is empty, or the consumer is taking the tail;
  // built from the tail backwards so in_ready never depends on in_valid
  always_comb begin
    w_ready = '0;
    w_acc   = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_acc      = w_acc || !r_vld[i];
      w_ready[i] = w_acc;
    end
  end

  // Pipeline advance: each ready stage takes its predecessor; data only moves with a valid beat
  always_ff @(posedge clkpos or negedge rstneg) begin
    if (!rstneg) begin
      r_vld <= '0;
      for (int i = 0; i < STAGES; i++) r_dat[i] <= '0;
    end else begin
      if (w_ready[0]) r_vld[0] <= in_valid;
      if (w_ready[0] && in_valid) r_dat[0] <= w_in;
      for (int i = 1; i < STAGES; i++) begin
        if (w_ready[i]) r_vld[i] <= r_vld[i-1];
        if (w_ready[i] && r_vld[i-1]) r_dat[i] <= r_dat[i-1];
      end
    end
  end

  // Completed output transfers, sticking at all-ones
  always_ff @(posedge clkpos or negedge rstneg) begin
    if (!rstneg) r_cnt <= '0;
    else if (out_valid && out_ready && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign in_ready  = w_ready[0];
  assign out_valid = r_vld[STAGES-1];
  assign out       = r_dat[STAGES-1][WIDTH-1:0];
  assign done_cnt  = r_cnt;

endmodule

// File: tb/tb_logic_pipe_nb.sv
// tb_logic_pipe_nb: directed self-checking bench for logic_pipe_nb (2-stage main instance, 1-stage 3-bit-counter instance)
module tb_logic_pipe_nb;
  logic clkpos = 1'b0;
  logic rstneg = 1'b0;
  always #5 clkpos = ~clkpos;

  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [1:0]  op = '0;
  logic        in_ready, out_valid, in_ready2, out_valid2;
  logic [15:0] out, out2, done_cnt;
  logic [2:0]  done_cnt2;
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
  logic        out_zero, out_zero2;
`endif
  int checks = 0;
  int failures = 0;

  logic_pipe_nb #(.WIDTH(16), .STAGES(2), .CNT_W(16)) dut (
    .clkpos(clkpos), .rstneg(rstneg), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .done_cnt(done_cnt)
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
    , .out_zero(out_zero)
`endif
  );

  logic_pipe_nb #(.WIDTH(16), .STAGES(1), .CNT_W(3)) dut2 (
    .clkpos(clkpos), .rstneg(rstneg), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .out_valid(out_valid2), .out_ready(out_ready2),
    .out(out2), .done_cnt(done_cnt2)
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
    , .out_zero(out_zero2)
`endif
  );

  task automatic tick();
    @(posedge clkpos);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_valid2 = 1'b0;
    rstneg = 1'b0;
    repeat (2) tick();
    rstneg = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    do_reset();
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (out !== 16'h0) begin failures++; $display("FAIL reset_out got=%h exp=0000", out); end
    if (done_cnt !== 16'h0) begin failures++; $display("FAIL reset_done_cnt got=%0d exp=0", done_cnt); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_ops();
    logic [15:0] exp [4];
    exp[0] = 16'hF000; exp[1] = 16'hFFF0; exp[2] = 16'h0FF0; exp[3] = 16'h000F;
    do_reset();
    out_ready = 1'b1;
    a = 16'hF0F0;
    b = 16'hFF00;
    for (int k = 0; k < 6; k++) begin
      in_valid = k < 4;
      op = 2'(k);
      tick();
      if (k >= 1 && k <= 4) begin
        checks++;
        if (out_valid !== 1'b1 || out !== exp[k-1]) begin
          failures++;
          $display("FAIL op_%0d got valid=%b out=%h exp valid=1 out=%h", k - 1, out_valid, out, exp[k-1]);
        end
      end
    end
    checks += 2;
    if (done_cnt !== 16'd4) begin failures++; $display("FAIL ops_done_cnt got=%0d exp=4", done_cnt); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL ops_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [15:0] vals [5];
    int idx, n;
    logic acc;
    for (int i = 0; i < 5; i++) vals[i] = 16'h1111 * 16'(i + 1);
    do_reset();
    out_ready = 1'b0;
    op = 2'b01;
    b = 16'h0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      a = vals[idx];
      #1;
      acc = in_ready;
      tick();
      if (acc) idx++;
      if (c >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out !== vals[0]) begin
          failures++;
          $display("FAIL stall_hold_%0d got valid=%b out=%h exp valid=1 out=%h", c, out_valid, out, vals[0]);
        end
      end
    end
    checks += 2;
    if (idx != 2) begin failures++; $display("FAIL stall_accepted got=%0d exp=2", idx); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    n = 0;
    for (int c = 0; c < 30 && n < 5; c++) begin
      in_valid = idx < 5;
      if (idx < 5) a = vals[idx];
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        checks++;
        if (out !== vals[n]) begin failures++; $display("FAIL drain_beat_%0d got=%h exp=%h", n, out, vals[n]); end
        n++;
      end
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    checks += 2;
    if (n != 5) begin failures++; $display("FAIL drain_count got=%0d exp=5", n); end
    if (done_cnt !== 16'd5) begin failures++; $display("FAIL bp_done_cnt got=%0d exp=5", done_cnt); end
  endtask

  task automatic test_stage1_saturation();
    do_reset();
    out_ready2 = 1'b0;
    in_valid2 = 1'b1;
    a = 16'h1234;
    b = 16'h0;
    op = 2'b01;
    tick();
    checks += 2;
    if (out_valid2 !== 1'b1 || out2 !== 16'h1234) begin
      failures++;
      $display("FAIL s1_latency got valid=%b out=%h exp valid=1 out=1234", out_valid2, out2);
    end
    if (in_ready2 !== 1'b0) begin failures++; $display("FAIL s1_full_in_ready got=%b exp=0", in_ready2); end
    out_ready2 = 1'b1;
    #1;
    checks++;
    if (in_ready2 !== 1'b1) begin failures++; $display("FAIL s1_release_in_ready got=%b exp=1", in_ready2); end
    repeat (3) tick();
    checks++;
    if (done_cnt2 !== 3'd3) begin failures++; $display("FAIL sat_partial got=%0d exp=3", done_cnt2); end
    repeat (7) tick();
    checks++;
    if (done_cnt2 !== 3'd7) begin failures++; $display("FAIL sat_final got=%0d exp=7", done_cnt2); end
    in_valid2 = 1'b0;
    out_ready2 = 1'b0;
  endtask

  task automatic test_midflight_reset();
    logic seen;
    do_reset();
    out_ready = 1'b1;
    op = 2'b01;
    b = 16'h0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a = 16'(k + 1);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (done_cnt !== 16'd1 || out_valid !== 1'b1 || out !== 16'h0002) begin
      failures++;
      $display("FAIL mid_pre got cnt=%0d valid=%b out=%h exp cnt=1 valid=1 out=0002", done_cnt, out_valid, out);
    end
    #2;
    rstneg = 1'b0;
    #1;
    checks += 2;
    if (out_valid !== 1'b0 || out !== 16'h0) begin
      failures++;
      $display("FAIL mid_async got valid=%b out=%h exp valid=0 out=0000", out_valid, out);
    end
    if (done_cnt !== 16'd0) begin failures++; $display("FAIL mid_done_cnt got=%0d exp=0", done_cnt); end
    #1;
    rstneg = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks += 2;
    if (seen !== 1'b0) begin failures++; $display("FAIL mid_stale got=%b exp=0", seen); end
    if (done_cnt !== 16'd0) begin failures++; $display("FAIL mid_cnt_after got=%0d exp=0", done_cnt); end
  endtask

`ifdef LOGIC_PIPE_ZERO_FLAG_EN
  task automatic test_zero_flag();
    do_reset();
    out_ready = 1'b1;
    a = 16'h00FF;
    b = 16'hFF00;
    in_valid = 1'b1;
    op = 2'b00;
    tick();
    op = 2'b01;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out !== 16'h0000 || out_zero !== 1'b1) begin
      failures++;
      $display("FAIL zero_and got out=%h z=%b exp out=0000 z=1", out, out_zero);
    end
    tick();
    checks++;
    if (out !== 16'hFFFF || out_zero !== 1'b0) begin
      failures++;
      $display("FAIL zero_or got out=%h z=%b exp out=ffff z=0", out, out_zero);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ops();
    test_backpressure();
    test_stage1_saturation();
    test_midflight_reset();
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
    test_zero_flag();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
